uno_sched: RTL and testbench

UNO_SCHED -- requirements
Module: uno_sched

---
 rtl/uno_sched_if.sv | 28 ++
 rtl/uno_sched.sv | 181 ++++++++++++++++++
 tb/tb_uno_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uno_sched_if.sv
// Command-side interface of the uno_sched scheduler.
// The master (command issuer) drives the command fields and abort; the
// slave (scheduler) answers with cmd_rdy.
interface uno_sched_if #(
    parameter int CNT_BW = 8
);
    logic              cmd_vld;
    logic              cmd_rdy;
    logic [1:0]        cmd_op;
    logic [CNT_BW-1:0] cmd_len;
    logic              abort;

    modport master (
        output cmd_vld,
        output cmd_op,
        output cmd_len,
        output abort,
        input  cmd_rdy
    );

    modport slave (
        input  cmd_vld,
        input  cmd_op,
        input  cmd_len,
        input  abort,
        output cmd_rdy
    );
endinterface

// File: rtl/uno_sched.sv
// uno_sched: command scheduler for a PE array that runs either a gemm
// stream or a unary series (div/exp/log) evaluated in Horner order.
//
// A command (op, len) is accepted in IDLE, streams len weight/coefficient
// indices in RUN, waits ARR_DEP cycles in DRAIN for the array pipeline to
// empty, then pulses done for one cycle in DONE.
//
// Optional feature: define UNO_SCHED_PERF_EN to build a saturating
// busy-cycle counter on perf_cnt; without it perf_cnt is tied to zero.
module uno_sched #(
    parameter int CNT_BW  = 8,
    parameter int ARR_DEP = 16,
    parameter int PERF_BW = 32
) (
    input  logic               clk,
    input  logic               rst,
    uno_sched_if.slave         cmd,
    output logic [1:0]         gemm_uno,
    output logic               x_en,
    output logic               wc_vld,
    output logic [CNT_BW-1:0]  wc_idx,
    output logic               busy,
    output logic               done,
    output logic [PERF_BW-1:0] perf_cnt
);

    // Drain counter only needs to reach ARR_DEP-1; keep at least one bit.
    localparam int DW = (ARR_DEP > 1) ? $clog2(ARR_DEP) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(ARR_DEP - 1);

    localparam logic [1:0] OP_GEMM = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              run_last;
    logic              drain_last;
    logic              is_gemm;

    // rem counts the RUN cycles still to go (including the current one),
    // so a full-scale len never needs a counter value above len.
    logic [CNT_BW-1:0] rem_q;
    logic [CNT_BW-1:0] idx_q;
    logic              first_q;
    logic [DW-1:0]     drain_q;

    assign accept     = (state == IDLE) && cmd.cmd_vld;
    assign run_last   = (rem_q == CNT_BW'(1));
    assign drain_last = (drain_q == DRAIN_LAST);
    assign is_gemm    = (gemm_uno == OP_GEMM);

    // State register; reset lands directly in IDLE, dropping any command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over every other transition outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd.cmd_len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cmd.abort) begin
                    state_nxt = IDLE;
                end else if (run_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (cmd.abort) begin
                    state_nxt = IDLE;
                end else if (drain_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch: mode is kept until the next accepted command, so the
    // array still sees the last mode while idle or after an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gemm_uno <= OP_GEMM;
        end else if (accept) begin
            gemm_uno <= cmd.cmd_op;
        end
    end

    // RUN bookkeeping: remaining-cycle count, coefficient index and the
    // first-cycle marker used to feed operands once for unary series.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
        end else if (accept) begin
            rem_q   <= cmd.cmd_len;
            first_q <= 1'b1;
            if (cmd.cmd_op == OP_GEMM || cmd.cmd_len == '0) begin
                idx_q <= '0;
            end else begin
                idx_q <= cmd.cmd_len - CNT_BW'(1);
            end
        end else if (state == RUN) begin
            first_q <= 1'b0;
            if (rem_q != '0) begin
                rem_q <= rem_q - CNT_BW'(1);
            end
            if (is_gemm) begin
                if (idx_q != '1) begin
                    idx_q <= idx_q + CNT_BW'(1);
                end
            end else begin
                if (idx_q != '0) begin
                    idx_q <= idx_q - CNT_BW'(1);
                end
            end
        end
    end

    // Drain timer: counts cycles spent in DRAIN, cleared everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_q <= '0;
        end else if (state == DRAIN) begin
            drain_q <= drain_q + DW'(1);
        end else begin
            drain_q <= '0;
        end
    end

    // Outputs are decoded from the state so they change exactly on the
    // edges that move the FSM; done is masked by abort so an aborted DONE
    // cycle reports no completion.
    assign cmd.cmd_rdy = (state == IDLE);
    assign busy        = (state != IDLE);
    assign wc_vld      = (state == RUN);
    assign x_en        = (state == RUN) && (is_gemm || first_q);
    assign wc_idx      = (state == RUN) ? idx_q : '0;
    assign done        = (state == DONE) && !cmd.abort;

`ifdef UNO_SCHED_PERF_EN
    // Busy-cycle counter, saturating at all-ones; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if (busy && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + PERF_BW'(1);
        end
    end
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_uno_sched.sv
// Directed testbench for uno_sched (CNT_BW=8, ARR_DEP=16, PERF_BW=32).
// Perf-counter expectations follow UNO_SCHED_PERF_EN when it is defined.
module tb_uno_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gemm_uno;
    logic        x_en;
    logic        wc_vld;
    logic [7:0]  wc_idx;
    logic        busy;
    logic        done;
    logic [31:0] perf_cnt;

    int checks = 0;
    int passes = 0;

    logic       tr_vld [0:299];
    logic       tr_xen [0:299];
    logic [7:0] tr_idx [0:299];
    logic       tr_done[0:299];
    logic       tr_rdy [0:299];

    logic [11:0] got;
    logic [11:0] exp_v;

    uno_sched_if #(.CNT_BW(8)) cmd_if ();

    uno_sched #(
        .CNT_BW (8),
        .ARR_DEP(16),
        .PERF_BW(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_if),
        .gemm_uno(gemm_uno),
        .x_en    (x_en),
        .wc_vld  (wc_vld),
        .wc_idx  (wc_idx),
        .busy    (busy),
        .done    (done),
        .perf_cnt(perf_cnt)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; returns in cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [7:0] len);
        cmd_if.cmd_op  = op;
        cmd_if.cmd_len = len;
        cmd_if.cmd_vld = 1'b1;
        step();
        cmd_if.cmd_vld = 1'b0;
    endtask

    // Record n consecutive cycles of outputs, starting with the current one.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr_vld[i]  = wc_vld;
            tr_xen[i]  = x_en;
            tr_idx[i]  = wc_idx;
            tr_done[i] = done;
            tr_rdy[i]  = cmd_if.cmd_rdy;
            step();
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        cmd_if.cmd_vld = 1'b0;
        cmd_if.cmd_op  = 2'b00;
        cmd_if.cmd_len = 8'd0;
        cmd_if.abort   = 1'b0;
        step();
        step();
        got   = {cmd_if.cmd_rdy, busy, done, wc_vld, x_en, gemm_uno, 5'd0};
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0};
        checks++;
        if (got !== exp_v)
            $display("[TB] FAIL reset_ctrl: got %b expected %b", got, exp_v);
        else
            passes++;
        checks++;
        if ({wc_idx, perf_cnt} !== 40'd0)
            $display("[TB] FAIL reset_data: idx %0d perf %0d expected 0 0", wc_idx, perf_cnt);
        else
            passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_gemm4();
        issue(2'b00, 8'd4);
        checks++;
        if (gemm_uno !== 2'b00)
            $display("[TB] FAIL gemm4_mode: got %b expected 00", gemm_uno);
        else
            passes++;
        capture(23);
        for (int i = 0; i < 23; i++) begin
            got   = {tr_vld[i], tr_xen[i], tr_idx[i], tr_done[i], tr_rdy[i]};
            exp_v = {(i < 4), (i < 4), (i < 4) ? 8'(i) : 8'd0, (i == 20), (i >= 21)};
            checks++;
            if (got !== exp_v)
                $display("[TB] FAIL gemm4_cycle T+%0d: got %b expected %b", i + 1, got, exp_v);
            else
                passes++;
        end
    endtask

    task automatic test_exp5();
        issue(2'b10, 8'd5);
        capture(24);
        for (int i = 0; i < 24; i++) begin
            got   = {tr_vld[i], tr_xen[i], tr_idx[i], tr_done[i], tr_rdy[i]};
            exp_v = {(i < 5), (i == 0), (i < 5) ? 8'(4 - i) : 8'd0, (i == 21), (i >= 22)};
            checks++;
            if (got !== exp_v)
                $display("[TB] FAIL exp5_cycle T+%0d: got %b expected %b", i + 1, got, exp_v);
            else
                passes++;
        end
        checks++;
        if ({gemm_uno, busy} !== {2'b10, 1'b0})
            $display("[TB] FAIL exp5_idle_mode: mode %b busy %b expected 10 0", gemm_uno, busy);
        else
            passes++;
    endtask

    task automatic test_log0();
        issue(2'b11, 8'd0);
        capture(3);
        for (int i = 0; i < 3; i++) begin
            got   = {tr_vld[i], tr_xen[i], tr_idx[i], tr_done[i], tr_rdy[i]};
            exp_v = {1'b0, 1'b0, 8'd0, (i == 0), (i >= 1)};
            checks++;
            if (got !== exp_v)
                $display("[TB] FAIL log0_cycle T+%0d: got %b expected %b", i + 1, got, exp_v);
            else
                passes++;
        end
        checks++;
        if (gemm_uno !== 2'b11)
            $display("[TB] FAIL log0_mode: got %b expected 11", gemm_uno);
        else
            passes++;
    endtask

    task automatic test_abort_run();
        issue(2'b01, 8'd8);
        step();
        step();
        cmd_if.abort = 1'b1;
        #1;
        checks++;
        if ({wc_vld, wc_idx} !== {1'b1, 8'd5})
            $display("[TB] FAIL abort_run_3rd: vld %b idx %0d expected 1 5", wc_vld, wc_idx);
        else
            passes++;
        step();
        cmd_if.abort = 1'b0;
        got   = {cmd_if.cmd_rdy, busy, done, wc_vld, x_en, gemm_uno, 5'd0};
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0};
        checks++;
        if (got !== exp_v)
            $display("[TB] FAIL abort_run_idle: got %b expected %b", got, exp_v);
        else
            passes++;
        issue(2'b01, 8'd2);
        capture(20);
        for (int i = 0; i < 20; i++) begin
            got   = {tr_vld[i], tr_xen[i], tr_idx[i], tr_done[i], tr_rdy[i]};
            exp_v = {(i < 2), (i == 0), (i < 2) ? 8'(1 - i) : 8'd0, (i == 18), (i >= 19)};
            checks++;
            if (got !== exp_v)
                $display("[TB] FAIL div2_after_abort T+%0d: got %b expected %b", i + 1, got, exp_v);
            else
                passes++;
        end
    endtask

    task automatic test_abort_done();
        issue(2'b11, 8'd0);
        cmd_if.abort = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b10)
            $display("[TB] FAIL abort_done_pulse: busy %b done %b expected 1 0", busy, done);
        else
            passes++;
        step();
        checks++;
        if ({cmd_if.cmd_rdy, done} !== 2'b10)
            $display("[TB] FAIL abort_done_idle: rdy %b done %b expected 1 0", cmd_if.cmd_rdy, done);
        else
            passes++;
        // abort held while idle must not block acceptance
        issue(2'b00, 8'd1);
        cmd_if.abort = 1'b0;
        capture(19);
        for (int i = 0; i < 19; i++) begin
            got   = {tr_vld[i], tr_xen[i], tr_idx[i], tr_done[i], tr_rdy[i]};
            exp_v = {(i == 0), (i == 0), 8'd0, (i == 17), (i >= 18)};
            checks++;
            if (got !== exp_v)
                $display("[TB] FAIL abort_idle_ignored T+%0d: got %b expected %b", i + 1, got, exp_v);
            else
                passes++;
        end
    endtask

    task automatic test_ignore_busy_cmd();
        issue(2'b00, 8'd3);
        cmd_if.cmd_op  = 2'b10;
        cmd_if.cmd_len = 8'd1;
        cmd_if.cmd_vld = 1'b1;
        step();
        step();
        cmd_if.cmd_vld = 1'b0;
        checks++;
        if ({gemm_uno, wc_idx} !== {2'b00, 8'd2})
            $display("[TB] FAIL ignore_mode: mode %b idx %0d expected 00 2", gemm_uno, wc_idx);
        else
            passes++;
        capture(19);
        for (int i = 0; i < 19; i++) begin
            got   = {tr_vld[i], tr_xen[i], tr_idx[i], tr_done[i], tr_rdy[i]};
            exp_v = {(i == 0), (i == 0), (i == 0) ? 8'd2 : 8'd0, (i == 17), (i >= 18)};
            checks++;
            if (got !== exp_v)
                $display("[TB] FAIL ignore_cycle T+%0d: got %b expected %b", i + 3, got, exp_v);
            else
                passes++;
        end
        step();
        step();
        checks++;
        if ({busy, gemm_uno} !== 3'b000)
            $display("[TB] FAIL ignore_no_queue: busy %b mode %b expected 0 00", busy, gemm_uno);
        else
            passes++;
    endtask

    task automatic test_reset_drain();
        logic [31:0] perf_exp;
        issue(2'b10, 8'd2);
        step();
        step();
        step();
        checks++;
        if ({busy, wc_vld} !== 2'b10)
            $display("[TB] FAIL rst_drain_pre: busy %b vld %b expected 1 0", busy, wc_vld);
        else
            passes++;
        rst = 1'b1;
        #1;
        got   = {cmd_if.cmd_rdy, busy, done, wc_vld, x_en, gemm_uno, 5'd0};
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0};
        checks++;
        if (got !== exp_v)
            $display("[TB] FAIL rst_drain_ctrl: got %b expected %b", got, exp_v);
        else
            passes++;
        perf_exp = 32'd0;
        checks++;
        if ({wc_idx, perf_cnt} !== {8'd0, perf_exp})
            $display("[TB] FAIL rst_drain_data: idx %0d perf %0d expected 0 %0d", wc_idx, perf_cnt, perf_exp);
        else
            passes++;
        step();
        rst = 1'b0;
        capture(25);
        for (int i = 0; i < 25; i++) begin
            got   = {tr_vld[i], tr_xen[i], tr_idx[i], tr_done[i], tr_rdy[i]};
            exp_v = {1'b0, 1'b0, 8'd0, 1'b0, 1'b1};
            checks++;
            if (got !== exp_v)
                $display("[TB] FAIL rst_drain_after +%0d: got %b expected %b", i, got, exp_v);
            else
                passes++;
        end
    endtask

    task automatic test_long_gemm();
        int          vld_n;
        int          xen_n;
        int          done_n;
        logic [31:0] perf_exp;
        vld_n  = 0;
        xen_n  = 0;
        done_n = 0;
        issue(2'b00, 8'd255);
        capture(273);
        for (int i = 0; i < 273; i++) begin
            if (tr_vld[i])  vld_n++;
            if (tr_xen[i])  xen_n++;
            if (tr_done[i]) done_n++;
        end
        checks++;
        if ({vld_n, xen_n, done_n} !== {32'd255, 32'd255, 32'd1})
            $display("[TB] FAIL long_counts: vld %0d xen %0d done %0d expected 255 255 1", vld_n, xen_n, done_n);
        else
            passes++;
        checks++;
        if ({tr_vld[254], tr_idx[254], tr_vld[255], tr_idx[255]} !== {1'b1, 8'd254, 1'b0, 8'd0})
            $display("[TB] FAIL long_last_idx: vld %b idx %0d next vld %b idx %0d expected 1 254 0 0",
                     tr_vld[254], tr_idx[254], tr_vld[255], tr_idx[255]);
        else
            passes++;
        checks++;
        if ({tr_done[271], tr_rdy[271], tr_rdy[272]} !== 3'b101)
            $display("[TB] FAIL long_done_time: done %b rdy %b rdy_next %b expected 1 0 1",
                     tr_done[271], tr_rdy[271], tr_rdy[272]);
        else
            passes++;
`ifdef UNO_SCHED_PERF_EN
        perf_exp = 32'd272;
`else
        perf_exp = 32'd0;
`endif
        checks++;
        if (perf_cnt !== perf_exp)
            $display("[TB] FAIL long_perf: got %0d expected %0d", perf_cnt, perf_exp);
        else
            passes++;
    endtask

    initial begin
        test_reset();
        test_gemm4();
        test_exp5();
        test_log0();
        test_abort_run();
        test_abort_done();
        test_ignore_busy_cmd();
        test_reset_drain();
        test_long_gemm();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
